// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch sequencer: fetch state encoding
// and default reset PC / increment constants.
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          DEFAULT_INC      = 4;

endpackage

// File: rtl/pc_fetch_unit_adder.sv
// Plain WIDTH-bit adder used for the sequential PC increment; the carry out is
// dropped so the result wraps modulo 2^WIDTH.
module pc_fetch_unit_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and one-outstanding instruction-fetch sequencer with a req/ack
// memory side and a valid/ready decode side. Optional redirect-target alignment
// check is enabled with the PC_ALIGN_CHECK_EN macro.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC),
    parameter int               INC      = DEFAULT_INC
) (
    input  logic             CLK,
    input  logic             RST,
    output logic             Imem_Req,
    output logic [WIDTH-1:0] Imem_Addr,
    input  logic             Imem_Ack,
    input  logic [WIDTH-1:0] Imem_Data,
    input  logic             Redirect_En,
    input  logic [WIDTH-1:0] Redirect_PC,
    output logic             Instr_Valid,
    input  logic             Instr_Ready,
    output logic [WIDTH-1:0] Instr_Out,
    output logic [WIDTH-1:0] Instr_PC
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic             Misalign
`endif
);

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);
`endif

    function automatic logic [WIDTH-1:0] align_target(input logic [WIDTH-1:0] t);
`ifdef PC_ALIGN_CHECK_EN
        return t & ALIGN_MASK;
`else
        return t;
`endif
    endfunction

    fetch_state_t     state_p0, state_nxt;
    logic [WIDTH-1:0] pc_p0, pc_nxt;
    logic [WIDTH-1:0] pc_inc;
    logic             req_p0, req_nxt;
    logic [WIDTH-1:0] addr_p0, addr_nxt;
    logic             vld_p0, vld_nxt;
    logic [WIDTH-1:0] instr_p0, instr_nxt;
    logic [WIDTH-1:0] ipc_p0, ipc_nxt;
    logic [WIDTH-1:0] target;

    pc_fetch_unit_adder #(
        .WIDTH (WIDTH)
    ) u_pc_adder (
        .a   (pc_p0),
        .b   (INC_W),
        .sum (pc_inc)
    );

    assign target = align_target(Redirect_PC);

    always_comb begin
        state_nxt = state_p0;
        pc_nxt    = pc_p0;
        req_nxt   = req_p0;
        addr_nxt  = addr_p0;
        vld_nxt   = vld_p0;
        instr_nxt = instr_p0;
        ipc_nxt   = ipc_p0;

        case (state_p0)
            IDLE: begin
                // A stale ack from before reset lands here and is ignored.
                state_nxt = REQ;
                req_nxt   = 1'b1;
                if (Redirect_En) begin
                    pc_nxt   = target;
                    addr_nxt = target;
                end else begin
                    addr_nxt = pc_p0;
                end
            end

            REQ: begin
                if (Redirect_En) begin
                    pc_nxt = target;
                    if (Imem_Ack) begin
                        addr_nxt  = target;
                        state_nxt = REQ;
                    end else begin
                        // Request already in flight; keep its address until it completes.
                        state_nxt = DROP;
                    end
                end else if (Imem_Ack) begin
                    instr_nxt = Imem_Data;
                    ipc_nxt   = pc_p0;
                    pc_nxt    = pc_inc;
                    req_nxt   = 1'b0;
                    vld_nxt   = 1'b1;
                    state_nxt = HOLD;
                end
            end

            HOLD: begin
                if (Redirect_En) begin
                    pc_nxt    = target;
                    vld_nxt   = 1'b0;
                    req_nxt   = 1'b1;
                    addr_nxt  = target;
                    state_nxt = REQ;
                end else if (Instr_Ready) begin
                    vld_nxt   = 1'b0;
                    req_nxt   = 1'b1;
                    addr_nxt  = pc_p0;
                    state_nxt = REQ;
                end
            end

            DROP: begin
                if (Redirect_En) begin
                    pc_nxt = target;
                end
                if (Imem_Ack) begin
                    addr_nxt  = Redirect_En ? target : pc_p0;
                    state_nxt = REQ;
                end
            end

            default: begin
                state_nxt = IDLE;
                req_nxt   = 1'b0;
                vld_nxt   = 1'b0;
            end
        endcase
    end

    // Stage p0: all architectural state and registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_p0 <= IDLE;
            pc_p0    <= RESET_PC;
            req_p0   <= 1'b0;
            addr_p0  <= RESET_PC;
            vld_p0   <= 1'b0;
            instr_p0 <= '0;
            ipc_p0   <= '0;
        end else begin
            state_p0 <= state_nxt;
            pc_p0    <= pc_nxt;
            req_p0   <= req_nxt;
            addr_p0  <= addr_nxt;
            vld_p0   <= vld_nxt;
            instr_p0 <= instr_nxt;
            ipc_p0   <= ipc_nxt;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic mis_p0;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mis_p0 <= 1'b0;
        end else begin
            mis_p0 <= Redirect_En && (Redirect_PC[1:0] != 2'b00);
        end
    end

    assign Misalign = mis_p0;
`endif

    assign Imem_Req    = req_p0;
    assign Imem_Addr   = addr_p0;
    assign Instr_Valid = vld_p0;
    assign Instr_Out   = instr_p0;
    assign Instr_PC    = ipc_p0;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a scoreboard queue holds each expected
// {PC, instruction} when the bench acks memory, popped when decode accepts.
module tb_pc_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST, RST1;
    logic        req, req1;
    logic [31:0] addr, addr1;
    logic        ack, ack1;
    logic [31:0] data, data1;
    logic        redir_en, redir_en1;
    logic [31:0] redir_pc, redir_pc1;
    logic        vld, vld1;
    logic        rdy, rdy1;
    logic [31:0] iout, iout1;
    logic [31:0] ipc, ipc1;
`ifdef PC_ALIGN_CHECK_EN
    logic        mis, mis1;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 CLK = ~CLK;

    pc_fetch_unit u0 (
        .CLK         (CLK),
        .RST         (RST),
        .Imem_Req    (req),
        .Imem_Addr   (addr),
        .Imem_Ack    (ack),
        .Imem_Data   (data),
        .Redirect_En (redir_en),
        .Redirect_PC (redir_pc),
        .Instr_Valid (vld),
        .Instr_Ready (rdy),
        .Instr_Out   (iout),
        .Instr_PC    (ipc)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .Misalign    (mis)
`endif
    );

    pc_fetch_unit #(
        .RESET_PC (32'hFFFF_FFFC)
    ) u1 (
        .CLK         (CLK),
        .RST         (RST1),
        .Imem_Req    (req1),
        .Imem_Addr   (addr1),
        .Imem_Ack    (ack1),
        .Imem_Data   (data1),
        .Redirect_En (redir_en1),
        .Redirect_PC (redir_pc1),
        .Instr_Valid (vld1),
        .Instr_Ready (rdy1),
        .Instr_Out   (iout1),
        .Instr_PC    (ipc1)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .Misalign    (mis1)
`endif
    );

    function automatic logic [31:0] memw(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory answers the current request this cycle and records what decode should see.
    task automatic mem_ack();
        exp_t e;
        ack  = 1'b1;
        data = memw(addr);
        e.pc  = addr;
        e.ins = memw(addr);
        sb.push_back(e);
    endtask

    task automatic pop_chk(input string tag);
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s: observed empty scoreboard expected pending entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_vld"}, 32'(vld), 32'd1);
            chk({tag, "_pc"}, ipc, e.pc);
            chk({tag, "_ins"}, iout, e.ins);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish within bound");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ack = 0; data = 0; redir_en = 0; redir_pc = 0; rdy = 0;
        ack1 = 0; data1 = 0; redir_en1 = 0; redir_pc1 = 0; rdy1 = 0;
        RST = 1'b1; RST1 = 1'b1;
        #2;
        RST = 1'b0; RST1 = 1'b0;
        repeat (2) step();

        chk("rst_req", 32'(req), 32'd0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_vld", 32'(vld), 32'd0);
        chk("rst_out", iout, 32'h0);
        chk("rst_ipc", ipc, 32'h0);
        chk("rst1_addr", addr1, 32'hFFFF_FFFC);
`ifdef PC_ALIGN_CHECK_EN
        chk("rst_mis", 32'(mis), 32'd0);
`endif

        RST = 1'b1;
        step();
        chk("boot_req", 32'(req), 32'd1);
        chk("boot_addr", addr, 32'h0);
        chk("boot_vld", 32'(vld), 32'd0);

        // Sequential fetch, zero-wait memory, decode always ready.
        rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("seq_req", 32'(req), 32'd1);
            chk("seq_addr", addr, 32'(i * 4));
            mem_ack();
            step();
            ack = 1'b0;
            chk("seq_req_low", 32'(req), 32'd0);
            pop_chk("seq");
            step();
            chk("seq_vld_low", 32'(vld), 32'd0);
        end

        // Decode stalls for 5 cycles.
        rdy = 1'b0;
        chk("stall_addr", addr, 32'hC);
        mem_ack();
        step();
        ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_vld", 32'(vld), 32'd1);
            chk("stall_req", 32'(req), 32'd0);
            chk("stall_ipc", ipc, 32'hC);
            chk("stall_out", iout, memw(32'hC));
            step();
        end
        rdy = 1'b1;
        pop_chk("stall");
        step();
        chk("stall_next_req", 32'(req), 32'd1);
        chk("stall_next_addr", addr, 32'h10);
        chk("stall_next_vld", 32'(vld), 32'd0);

        // Redirect while request outstanding; ack arrives 3 cycles later.
        redir_en = 1'b1;
        redir_pc = 32'h100;
        step();
        redir_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("drop_req", 32'(req), 32'd1);
            chk("drop_addr", addr, 32'h10);
            chk("drop_vld", 32'(vld), 32'd0);
            step();
        end
        chk("drop_addr_ack", addr, 32'h10);
        ack  = 1'b1;
        data = memw(32'h10);
        step();
        ack = 1'b0;
        chk("drop_no_vld", 32'(vld), 32'd0);
        chk("drop_new_req", 32'(req), 32'd1);
        chk("drop_new_addr", addr, 32'h100);
        mem_ack();
        step();
        ack = 1'b0;
        pop_chk("after_drop");
        step();
        chk("after_drop_addr", addr, 32'h104);

        // Redirect in HOLD with decode accepting the same cycle.
        mem_ack();
        step();
        ack = 1'b0;
        pop_chk("hold_redir");
        redir_en = 1'b1;
        redir_pc = 32'h200;
        step();
        redir_en = 1'b0;
        chk("hold_redir_vld", 32'(vld), 32'd0);
        chk("hold_redir_req", 32'(req), 32'd1);
        chk("hold_redir_addr", addr, 32'h200);

        // Redirect coincident with ack in REQ: word discarded.
        ack      = 1'b1;
        data     = memw(32'h200);
        redir_en = 1'b1;
        redir_pc = 32'h300;
        step();
        ack      = 1'b0;
        redir_en = 1'b0;
        chk("req_ack_redir_addr", addr, 32'h300);
        chk("req_ack_redir_req", 32'(req), 32'd1);
        chk("req_ack_redir_vld", 32'(vld), 32'd0);
        mem_ack();
        step();
        ack = 1'b0;
        pop_chk("req_ack_redir");
        step();
        chk("req_ack_redir_next", addr, 32'h304);

`ifdef PC_ALIGN_CHECK_EN
        ack      = 1'b1;
        data     = memw(32'h304);
        redir_en = 1'b1;
        redir_pc = 32'h102;
        step();
        ack      = 1'b0;
        redir_en = 1'b0;
        chk("mis_addr", addr, 32'h100);
        chk("mis_pulse", 32'(mis), 32'd1);
        step();
        chk("mis_clear", 32'(mis), 32'd0);
`endif

        // Asynchronous reset mid-operation, stale ack after release.
        RST = 1'b0;
        #1;
        chk("mid_rst_req", 32'(req), 32'd0);
        chk("mid_rst_vld", 32'(vld), 32'd0);
        chk("mid_rst_addr", addr, 32'h0);
        step();
        RST  = 1'b1;
        ack  = 1'b1;
        data = 32'hDEAD_BEEF;
        step();
        ack = 1'b0;
        chk("stale_ack_vld", 32'(vld), 32'd0);
        chk("stale_ack_req", 32'(req), 32'd1);
        chk("stale_ack_addr", addr, 32'h0);
        step();
        chk("stale_ack_vld2", 32'(vld), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        // PC wrap from 0xFFFF_FFFC.
        RST1 = 1'b1;
        step();
        chk("wrap_req", 32'(req1), 32'd1);
        chk("wrap_addr0", addr1, 32'hFFFF_FFFC);
        ack1  = 1'b1;
        data1 = memw(32'hFFFF_FFFC);
        rdy1  = 1'b1;
        step();
        ack1 = 1'b0;
        chk("wrap_vld", 32'(vld1), 32'd1);
        chk("wrap_ipc", ipc1, 32'hFFFF_FFFC);
        chk("wrap_out", iout1, memw(32'hFFFF_FFFC));
        step();
        chk("wrap_req2", 32'(req1), 32'd1);
        chk("wrap_addr1", addr1, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
